// File: rtl/tile_painter.sv
// tile_painter: maps VGA coordinates to banner/board regions, fetches tile and icon texels,
// overlays a blinking cursor outline and emits colour with aligned syncs at fixed latency.
module tile_painter #(
  parameter int TILE_LOG2 = 5,
  parameter int GRID_COLS = 10,
  parameter int GRID_ROWS = 10,
  parameter int NUM_BOARDS = 2,
  parameter int TOP_H = 100,
  parameter int TILE_CODE_W = 4,
  parameter int COLOR_W = 12,
  parameter logic [COLOR_W-1:0] TOP_COLOR = 12'hFFF,
  parameter logic [COLOR_W-1:0] BOTTOM_COLOR = 12'h0FF,
  parameter logic [COLOR_W-1:0] CURSOR_COLOR = 12'hF00,
  parameter int BLINK_LOG2 = 5,
  localparam int BW = NUM_BOARDS > 1 ? $clog2(NUM_BOARDS) : 1,
  localparam int AW = $clog2(NUM_BOARDS*GRID_COLS*GRID_ROWS),
  localparam int IW = TILE_CODE_W + 2*TILE_LOG2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               vid_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               cursor_en,
  input  logic [BW-1:0]      cursor_board,
  input  logic [3:0]         cursor_col,
  input  logic [3:0]         cursor_row,
  output logic [AW-1:0]      tile_addr,
  input  logic [TILE_CODE_W-1:0] tile_data,
  output logic [IW-1:0]      icon_addr,
  input  logic [COLOR_W-1:0] icon_data,
  output logic [COLOR_W-1:0] screen_color,
  output logic               hsync_out,
  output logic               vsync_out
);
  localparam int BOARD_W = NUM_BOARDS*GRID_COLS*(1 << TILE_LOG2);
  localparam int BOT_Y = TOP_H + GRID_ROWS*(1 << TILE_LOG2);
  localparam int FW = BLINK_LOG2 + 1;
  typedef enum logic [1:0] {R_TOP, R_BOARD, R_BOT} region_t;
  typedef struct packed {
    region_t r;
    logic    v;
    logic    h;
    logic    hs;
    logic    vs;
  } side_t;
  localparam side_t SD_RST = '{r: R_TOP, v: 1'b0, h: 1'b0, hs: 1'b1, vs: 1'b1};
  side_t sd [4];
  logic [2*TILE_LOG2-1:0] off [2];
  logic [FW-1:0] frame;
  logic vs_q;
  region_t region;
  logic [9:0] yr, tx, b, col, row;
  logic [TILE_LOG2-1:0] ox, oy;
  logic [AW-1:0] addr;
  logic hit;
  logic [COLOR_W-1:0] color;
  always_comb begin
    yr = pixel_y - 10'(TOP_H);
    tx = pixel_x >> TILE_LOG2;
    b = 10'(tx / GRID_COLS);
    col = 10'(tx % GRID_COLS);
    row = yr >> TILE_LOG2;
    ox = pixel_x[TILE_LOG2-1:0];
    oy = yr[TILE_LOG2-1:0];
    addr = AW'(32'(b)*GRID_COLS*GRID_ROWS + 32'(row)*GRID_COLS + 32'(col));
    region = 32'(pixel_y) < TOP_H ? R_TOP :
             (32'(pixel_y) >= BOT_Y || 32'(pixel_x) >= BOARD_W) ? R_BOT : R_BOARD;
    // only in-range board tiles can match, so out-of-range cursor coordinates never hit
    hit = region == R_BOARD && cursor_en && !frame[FW-1] &&
          10'(cursor_board) == b && 10'(cursor_col) == col && 10'(cursor_row) == row &&
          (ox == '0 || ox == '1 || oy == '0 || oy == '1);
    color = !sd[3].v ? '0 : sd[3].r == R_TOP ? TOP_COLOR : sd[3].r == R_BOT ? BOTTOM_COLOR :
            sd[3].h ? CURSOR_COLOR : icon_data;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) sd[i] <= SD_RST;
      off[0] <= '0;
      off[1] <= '0;
      tile_addr <= '0;
      icon_addr <= '0;
      screen_color <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      frame <= '0;
      vs_q <= 1'b1;
    end else begin
      sd[0] <= '{r: region, v: vid_on, h: hit, hs: hsync_in, vs: vsync_in};
      for (int i = 1; i < 4; i++) sd[i] <= sd[i-1];
      off[0] <= {oy, ox};
      off[1] <= off[0];
      if (region == R_BOARD) tile_addr <= addr;
      if (sd[1].r == R_BOARD) icon_addr <= {tile_data, off[1]};
      screen_color <= color;
      hsync_out <= sd[3].hs;
      vsync_out <= sd[3].vs;
      vs_q <= vsync_in;
      if (vs_q && !vsync_in) frame <= frame + 1'b1;
    end
  end
endmodule

// File: tb/tb_tile_painter.sv
// tb_tile_painter: randomized scoreboard bench with tile RAM / icon ROM models.
module tb_tile_painter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic vid_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic cursor_en = 1'b0;
  logic [0:0] cursor_board = '0;
  logic [3:0] cursor_col = '0, cursor_row = '0;
  logic [7:0] tile_addr;
  logic [3:0] tile_data;
  logic [13:0] icon_addr;
  logic [11:0] icon_data, screen_color;
  logic hsync_out, vsync_out;
  typedef struct {int due; logic [11:0] c; logic hs; logic vs;} cexp_t;
  typedef struct {int due; logic [13:0] a;} iexp_t;
  cexp_t cq [$];
  iexp_t iq [$];
  logic [3:0] ram [256];
  int edge_cnt = 0;
  int checks = 0, fails = 0;
  int exp_tile = 0, frame = 0;
  logic prev_vs = 1'b1;
  tile_painter dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .vid_on(vid_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .cursor_en(cursor_en),
    .cursor_board(cursor_board), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .tile_addr(tile_addr), .tile_data(tile_data), .icon_addr(icon_addr),
    .icon_data(icon_data), .screen_color(screen_color), .hsync_out(hsync_out),
    .vsync_out(vsync_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  function automatic logic [11:0] rom(input logic [13:0] a);
    return a[11:0] ^ {a[13:12], a[13:4]} ^ 12'h5A3;
  endfunction
  always @(posedge clk) begin
    tile_data <= ram[tile_addr];
    icon_data <= rom(icon_addr);
  end
  initial forever begin
    @(posedge clk);
    #1;
    while (cq.size() > 0 && cq[0].due <= edge_cnt) begin
      cexp_t e;
      e = cq.pop_front();
      checks++;
      if (e.due != edge_cnt || screen_color !== e.c || hsync_out !== e.hs || vsync_out !== e.vs) begin
        fails++;
        $display("FAIL colour edge %0d: got c=%h hs=%b vs=%b, want c=%h hs=%b vs=%b",
                 edge_cnt, screen_color, hsync_out, vsync_out, e.c, e.hs, e.vs);
      end
    end
    while (iq.size() > 0 && iq[0].due <= edge_cnt) begin
      iexp_t e;
      e = iq.pop_front();
      checks++;
      if (e.due != edge_cnt || icon_addr !== e.a) begin
        fails++;
        $display("FAIL icon_addr edge %0d: got %h, want %h", edge_cnt, icon_addr, e.a);
      end
    end
  end
  task automatic drive(input logic r, input int x, input int y, input logic vid, input logic hs, input logic vs);
    int n, bx, lx, col, row, ox, oy, addr;
    logic [11:0] c;
    logic vis, hit;
    @(negedge clk);
    rst = r;
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    vid_on = vid;
    hsync_in = hs;
    vsync_in = vs;
    n = edge_cnt + 1;
    if (!r) begin
      cq.delete();
      iq.delete();
      for (int k = 0; k < 5; k++) cq.push_back('{n + k, 12'h000, 1'b1, 1'b1});
      iq.push_back('{n, 14'h0});
      exp_tile = 0;
      frame = 0;
      prev_vs = 1'b1;
    end else begin
      vis = frame < 32;
      c = 12'h000;
      if (y >= 100 && y < 420 && x < 640) begin
        bx = x / 320;
        lx = x % 320;
        col = lx / 32;
        ox = lx % 32;
        row = (y - 100) / 32;
        oy = (y - 100) % 32;
        addr = bx * 100 + row * 10 + col;
        exp_tile = addr;
        iq.push_back('{n + 2, {ram[addr], 5'(oy), 5'(ox)}});
        hit = cursor_en && int'(cursor_board) == bx && int'(cursor_col) == col &&
              int'(cursor_row) == row && vis && (ox == 0 || ox == 31 || oy == 0 || oy == 31);
        if (vid) c = hit ? 12'hF00 : rom({ram[addr], 5'(oy), 5'(ox)});
      end else if (vid) c = y < 100 ? 12'hFFF : 12'h0FF;
      cq.push_back('{n + 4, c, hs, vs});
      if (prev_vs && !vs) frame = (frame + 1) % 64;
      prev_vs = vs;
    end
    @(posedge clk);
    #1;
    checks++;
    if (tile_addr !== 8'(exp_tile)) begin
      fails++;
      $display("FAIL tile_addr edge %0d: got %0d, want %0d", edge_cnt, tile_addr, exp_tile);
    end
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b1, 700, 500, 1'b0, 1'b1, 1'b1);
  endtask
  task automatic vfalls(input int k);
    for (int i = 0; i < k; i++) begin
      drive(1'b1, 700, 470, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 700, 471, 1'b0, 1'b1, 1'b1);
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 4'($urandom);
    ram[11] = 4'd3;
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++)
      drive(1'b1, $urandom_range(0, 799), $urandom_range(0, 524), 1'b0, 1'($urandom), 1'($urandom));
    drive(1'b1, 37, 140, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 330, 100, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 639, 419, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 200, 99, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 200, 420, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 640, 200, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 0, 0, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 0, 100, 1'b1, 1'b1, 1'b1);
    idle(5);
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    cursor_en = 1'b1;
    cursor_board = 1'b0;
    cursor_col = 4'd2;
    cursor_row = 4'd3;
    drive(1'b1, 64, 196, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 80, 210, 1'b1, 1'b1, 1'b1);
    vfalls(32);
    drive(1'b1, 64, 196, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 80, 210, 1'b1, 1'b1, 1'b1);
    vfalls(32);
    drive(1'b1, 64, 196, 1'b1, 1'b1, 1'b1);
    cursor_col = 4'd12;
    drive(1'b1, 384, 196, 1'b1, 1'b1, 1'b1);
    cursor_col = 4'd2;
    for (int i = 0; i < 6; i++) drive(1'b1, 64 + i, 196, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 64, 196, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, 64 + i, 196, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      int x, y;
      if ($urandom_range(0, 199) == 0) begin
        cursor_en = 1'($urandom);
        cursor_board = 1'($urandom);
        cursor_col = 4'($urandom);
        cursor_row = 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        x = int'(cursor_board) * 320 + int'(cursor_col) * 32 + $urandom_range(0, 31);
        y = 100 + int'(cursor_row) * 32 + $urandom_range(0, 31);
      end else begin
        x = $urandom_range(0, 799);
        y = $urandom_range(0, 524);
      end
      drive($urandom_range(0, 499) != 0, x, y, $urandom_range(0, 7) != 0,
            1'($urandom), $urandom_range(0, 7) != 0);
    end
    idle(8);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
